// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction-fetch / data shared-memory arbiter with one-cycle read return
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} state_t;

  state_t state;
  logic   fetch_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  // Saturated count of back-to-back denied fetch cycles; at the limit fetch wins once.
  assign fetch_force = if_req && (starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign fetch_force = 1'b0;
  assign unused_cfg  = (STARVE_MAX != 0);
`endif

  // Grants are gated by rst so nothing issues while reset is held.
  assign d_gnt  = rst && d_req && !fetch_force;
  assign if_gnt = rst && if_req && !d_gnt;

  assign mem_en   = if_gnt || d_gnt;
  assign mem_we   = d_gnt ? d_we : 4'b0000;
  assign mem_addr = d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
  assign mem_din  = d_wdata;
  assign stall    = (if_req && !if_gnt) || (d_req && !d_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (d_gnt) begin
      state <= (d_we != 4'b0000) ? D_WR : D_RD;
    end else if (if_gnt) begin
      state <= IF_RD;
    end else begin
      state <= IDLE;
    end
  end

  assign if_rvalid = (state == IF_RD);
  assign d_rvalid  = (state == D_RD);
  assign if_rdata  = mem_dout;
  assign d_rdata   = mem_dout;

  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  localparam int AW = 14;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0;
  logic [31:0]   if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]    d_we = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, stall;
  logic [31:0]   if_rdata, d_rdata, mem_din;
  logic [31:0]   mem_dout = '0;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // External synchronous RAM with one-cycle read latency; dout is noise when idle.
  logic [31:0] dev_mem [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) dev_mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= dev_mem[mem_addr];
    end else begin
      mem_dout <= $urandom;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: shadow memory, pending read return, denied-fetch run length.
  logic [31:0] shadow [1<<AW];
  bit          pend_if, pend_d;
  logic [31:0] pend_data;
  int          denied;
  logic        obs_if_gnt, obs_stall;
  logic [AW-1:0] obs_addr;
  logic [3:0]  obs_we;
  logic [31:0] obs_din;

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    bit force_if, e_d, e_if;
    logic [AW-1:0] idx;
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
    force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_if = ir && (denied >= SM);
`endif
    e_d  = dr && !force_if;
    e_if = ir && !e_d;
    idx  = e_d ? da[AW+1:2] : ia[AW+1:2];
    check("if_gnt", if_gnt, e_if);
    check("d_gnt", d_gnt, e_d);
    check("stall", stall, (ir && !e_if) || (dr && !e_d));
    check("mem_en", mem_en, e_if || e_d);
    check("mem_we", mem_we, e_d ? dw : 4'b0);
    check("mem_din", mem_din, dd);
    if (e_if || e_d) check("mem_addr", mem_addr, idx);
    check("if_rvalid", if_rvalid, pend_if);
    check("d_rvalid", d_rvalid, pend_d);
    if (pend_if) check("if_rdata", if_rdata, pend_data);
    if (pend_d) check("d_rdata", d_rdata, pend_data);
    obs_if_gnt = if_gnt; obs_stall = stall; obs_addr = mem_addr; obs_we = mem_we; obs_din = mem_din;
    pend_if   = e_if;
    pend_d    = e_d && (dw == 4'b0);
    pend_data = shadow[idx];
    if (e_d)
      for (int b = 0; b < 4; b++)
        if (dw[b]) shadow[idx][8*b +: 8] = dd[8*b +: 8];
    denied = (ir && !e_if) ? ((denied < SM) ? denied + 1 : SM) : 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_gnt"}, if_gnt, 1'b0);
    check({tag, "_d_gnt"}, d_gnt, 1'b0);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_we"}, mem_we, 4'b0);
    check({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    check({tag, "_d_rvalid"}, d_rvalid, 1'b0);
  endtask

  task automatic reset_mid_read(input logic [31:0] da);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 4'b0; d_addr = da;
    #1 check("rmr_d_gnt_before", d_gnt, 1'b1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rmr_low");
    @(posedge clk); #1 check_reset_outputs("rmr_edge");
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    pend_if = 1'b0; pend_d = 1'b0; denied = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 63));
    return a;
  endfunction

  logic [7:0] gseq;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dev_mem[i] = $urandom;
      shadow[i]  = dev_mem[i];
    end
    pend_if = 1'b0; pend_d = 1'b0; denied = 0;
    if_req = 1'b1; d_req = 1'b1; d_we = 4'b0;
    #2 check_reset_outputs("por");
    @(posedge clk); #1 check_reset_outputs("por_edge");
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #2 rst = 1'b1;

    step(1, 32'h0000_0104, 0, 4'b0, 32'h0, 32'h0);
    check("fetch104_addr", obs_addr, 14'h041);
    step(0, 32'h0, 0, 4'b0, 32'h0, 32'h0);
    step(1, 32'h0000_0300, 1, 4'b0, 32'h0000_0200, 32'h0);
    check("conflict_stall", obs_stall, 1'b1);
    check("conflict_addr", obs_addr, 14'h080);
    step(1, 32'h0000_0300, 0, 4'b0, 32'h0, 32'h0);
    step(0, 32'h0, 1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF);
    check("store_we", obs_we, 4'b0011);
    check("store_din", obs_din, 32'hDEAD_BEEF);
    check("store_addr", obs_addr, 14'h004);
    step(0, 32'h0, 1, 4'b0, 32'h0000_0010, 32'h0);
    step(0, 32'h0, 0, 4'b0, 32'h0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      step(1, 32'h0000_0400 + 32'(4 * i), 1, 4'b0, 32'h0000_0080, 32'h0);
      gseq[i] = obs_if_gnt;
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_seq", {24'h0, gseq}, 32'h0000_0088);
`else
    check("starve_seq", {24'h0, gseq}, 32'h0000_0000);
`endif
    step(0, 32'h0, 0, 4'b0, 32'h0, 32'h0);

    for (int i = 0; i < 3; i++) step(1, 32'(4 * i), 0, 4'b0, 32'h0, 32'h0);
    step(0, 32'h0, 0, 4'b0, 32'h0, 32'h0);

    reset_mid_read(32'h0000_0200);
    step(0, 32'h0, 0, 4'b0, 32'h0, 32'h0);
    step(1, 32'h0000_0008, 1, 4'b0, 32'h0000_0020, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_mid_read(rand_addr());
      step(($urandom_range(0, 3) != 0), rand_addr(),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0) ? 4'b0 : 4'($urandom),
           rand_addr(), $urandom);
    end
    step(0, 32'h0, 0, 4'b0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
